lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- MEM-stage load/store controller for the pipelined core. It is the initiator that drives the data_memory port (address, dataWr, dmCtrl, dmWr) and consumes dataRd.
- Converts one pipeline load/store request (funct3-coded size and sign) into a sequence of aligned word accesses.
- Performs read-modify-write for sub-word stores and splits misaligned accesses that cross a word boundary.
- Stalls the pipeline through req_ready and returns the load result on a one-cycle rsp_valid pulse.

Parameters:
- ADDR_W, 32, byte-address width; word index is ADDR_W-1:2.
- SKIP_RD_FULL_WORD, 1, when 1 an aligned sw (ctrl 010, addr[1:0]=0) skips the read phase.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX/MEM register.
- req_ready  out  1  controller idle; request accepted on clk edge when req_valid&&req_ready.
- req_wr  in  1  1=store, 0=load.
- req_ctrl  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (loads); stores use 000/001/010.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load result; 0 for stores.
- rsp_err  out  1  valid with rsp_valid; illegal ctrl, or misaligned under MISALIGN_TRAP_EN.
- dm_address  out  ADDR_W  to data_memory.address; always word-aligned.
- dm_dataWr  out  32  to data_memory.dataWr.
- dm_dmCtrl  out  3  to data_memory.dmCtrl; always 010 while active, 000 in IDLE.
- dm_dmWr  out  1  to data_memory.dmWr.
- dm_dataRd  in  32  from data_memory.dataRd; combinational read of dm_address.

Behaviour:
- Memory is little-endian. A read is valid in the same cycle dm_address is driven. A write commits at the clk edge that ends a cycle with dm_dmWr=1.
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; dm_address=0, dm_dataWr=0, dm_dmCtrl=000, dm_dmWr=0; internal latches cleared.
- Reset mid-operation aborts at once. dm_dmWr falls with rst_n, no further write is issued, and no rsp is produced.
- State machine states: IDLE, RD0, RD1, WR0, WR1, DONE. All dm_* outputs are registered/decoded from state and latched request only, never combinational from req_*.
- IDLE: req_ready=1. On accept, latch wr/ctrl/addr/wdata and compute size (1/2/4) and span=(addr[1:0]+size>4). Next state is DONE with err if ctrl is illegal (011, 110, 111, or a store with ctrl 1xx); otherwise WR0 for an aligned sw when SKIP_RD_FULL_WORD=1; otherwise RD0.
- RD0: dm_address={addr[31:2],00}; capture dm_dataRd into w0. Next state RD1 if span, else WR0 for a store, else DONE.
- RD1: dm_address=word0+4, wrapping modulo 2^ADDR_W; capture w1. Next state WR0 for a store, else DONE.
- WR0: dm_dmWr=1; dm_dataWr=w0 with the store bytes merged at lanes addr[1:0] upward. Next state WR1 if span, else DONE.
- WR1: dm_dmWr=1; dm_address=word0+4; dm_dataWr=w1 with the remaining store bytes merged from lane 0. Next state DONE.
- DONE: rsp_valid=1 for exactly one cycle. For loads, rsp_rdata = bytes extracted from {w1,w0} at offset addr[1:0], sign-extended for b/h and zero-extended for bu/hu. rsp_rdata holds its value until the next DONE. Next state IDLE; req_ready returns to 1 the following cycle.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored; the pipeline holds the request.
- Latency in cycles after the accept edge, counting the rsp_valid cycle:
  - aligned load: 2
  - misaligned spanning load: 3
  - aligned sw: 2
  - aligned sub-word store: 3
  - spanning store: 5
  - error: 1
- A non-spanning misaligned access (e.g. lh at offset 1) is handled as aligned, with a single word access.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: any access with addr not aligned to its size (h with addr[0]=1; w with addr[1:0]!=0) goes IDLE->DONE with rsp_err=1, rsp_rdata=0, and no dm access. RD1 and WR1 are unreachable.
- Undefined: misaligned accesses are executed as above; rsp_err is set only for illegal ctrl.

Test Plan:
- Reset: hold rst_n=0 mid-random-traffic -> all outputs at their reset values immediately, req_ready=1; release, then idle for 3 cycles -> no dm_dmWr.
- sb: mem[0x6C]=0xAABBCCDD, store addr 0x6E, wdata 0x09, ctrl 000 -> RD0 reads 0x6C; WR0 writes 0xAA09CCDD to 0x6C; rsp_valid in cycle 3, rsp_err=0.
- lh/lhu: mem[0x20]=0x0000BCDE, load addr 0x20 -> ctrl 001 gives rsp_rdata 0xFFFFBCDE and ctrl 101 gives 0x0000BCDE; rsp_valid in cycle 2.
- sw: addr 0x30, wdata 0x12345678, ctrl 010 -> one cycle with dm_address 0x30, dm_dmWr=1, dm_dataWr 0x12345678, and no read phase; rsp_valid in cycle 2.
- Misaligned lw at addr 0x32, mem[0x30]=0x5678AAAA, mem[0x34]=0xBBBB1234:
  - macro undefined -> reads 0x30 then 0x34; rsp_rdata 0x12345678 in cycle 3.
  - MISALIGN_TRAP_EN defined -> rsp_err=1 in cycle 1, no dm access.
- Misaligned sh at addr 0x33, with rst_n pulsed low during WR0 -> dm_dmWr drops immediately, no WR1 write to 0x34, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : MEM-stage load/store controller. Splits each request into aligned
//            word accesses, does read-modify-write for sub-word stores, and
//            optionally traps misaligned accesses (macro MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int ADDR_W            = 32,
    parameter bit SKIP_RD_FULL_WORD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_dataWr,
    output logic [2:0]        dm_dmCtrl,
    output logic              dm_dmWr,
    input  logic [31:0]       dm_dataRd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [2:0] c_DM_WORD = 3'b010;
    localparam logic [2:0] c_DM_IDLE = 3'b000;

    state_t              r_state;
    logic                r_wr;
    logic [2:0]          r_ctrl;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_size;
    logic                r_span;
    logic [31:0]         r_w0;
    logic [31:0]         r_w1;

    logic [2:0]          w_reqSize;
    logic                w_reqSpan;
    logic                w_reqIllegal;
    logic                w_reqTrap;
    logic                w_reqSkipRead;
    logic [ADDR_W-1:0]   w_reqWord0;
    logic [ADDR_W-1:0]   w_word0;
    logic [ADDR_W-1:0]   w_word1;
    logic [31:0]         w_mergeRd0;
    logic [31:0]         w_mergeW0;
    logic [31:0]         w_mergeW1;
    logic [31:0]         w_loadRd0;
    logic [31:0]         w_loadRd1;

    // Store bytes placed at lane 'off' upward in the {w1,w0} pair; hi picks w1.
    function automatic logic [31:0] mergeWord(input logic [63:0] oldPair, input logic [31:0] data,
                                              input logic [1:0] off, input logic [2:0] size,
                                              input logic hi);
        logic [63:0] sizeMask;
        logic [63:0] bitMask;
        logic [63:0] merged;
        case (size)
            3'd1:    sizeMask = 64'h0000_0000_0000_00FF;
            3'd2:    sizeMask = 64'h0000_0000_0000_FFFF;
            default: sizeMask = 64'h0000_0000_FFFF_FFFF;
        endcase
        bitMask = sizeMask << {off, 3'b000};
        merged  = (oldPair & ~bitMask) | (({32'h0, data} << {off, 3'b000}) & bitMask);
        return hi ? merged[63:32] : merged[31:0];
    endfunction

    function automatic logic [31:0] extractLoad(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [2:0] ctrl);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (ctrl)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        case (req_ctrl[1:0])
            2'b00:   w_reqSize = 3'd1;
            2'b01:   w_reqSize = 3'd2;
            default: w_reqSize = 3'd4;
        endcase
    end

    assign w_reqSpan     = ({1'b0, req_addr[1:0]} + w_reqSize) > 3'd4;
    assign w_reqIllegal  = (req_ctrl == 3'b011) || (req_ctrl[2:1] == 2'b11) || (req_wr && req_ctrl[2]);
    assign w_reqSkipRead = SKIP_RD_FULL_WORD && req_wr && (req_ctrl == 3'b010) && (req_addr[1:0] == 2'b00);
    assign w_reqWord0    = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign w_reqTrap = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_reqTrap = 1'b0;
`endif

    assign w_word0    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_word1    = w_word0 + ADDR_W'(4);
    assign w_mergeRd0 = mergeWord({32'h0, dm_dataRd}, r_wdata, r_addr[1:0], r_size, 1'b0);
    assign w_mergeW0  = mergeWord({32'h0, r_w0}, r_wdata, r_addr[1:0], r_size, 1'b0);
    assign w_mergeW1  = mergeWord({r_w1, 32'h0}, r_wdata, r_addr[1:0], r_size, 1'b1);
    assign w_loadRd0  = extractLoad({32'h0, dm_dataRd}, r_addr[1:0], r_ctrl);
    assign w_loadRd1  = extractLoad({dm_dataRd, r_w0}, r_addr[1:0], r_ctrl);

    // dm_* and rsp_* are loaded on the edge entering the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr       <= 1'b0;
            r_ctrl     <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_size     <= 3'd0;
            r_span     <= 1'b0;
            r_w0       <= 32'h0;
            r_w1       <= 32'h0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
            dm_address <= '0;
            dm_dataWr  <= 32'h0;
            dm_dmCtrl  <= c_DM_IDLE;
            dm_dmWr    <= 1'b0;
        end else begin
            rsp_valid  <= 1'b0;
            dm_dmWr    <= 1'b0;
            dm_dmCtrl  <= c_DM_IDLE;
            dm_address <= '0;
            dm_dataWr  <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_wr      <= req_wr;
                        r_ctrl    <= req_ctrl;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_size    <= w_reqSize;
                        r_span    <= w_reqSpan;
                        r_w0      <= 32'h0;
                        r_w1      <= 32'h0;
                        req_ready <= 1'b0;
                        if (w_reqIllegal || w_reqTrap) begin
                            r_state   <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else if (w_reqSkipRead) begin
                            r_state    <= WR0;
                            dm_dmCtrl  <= c_DM_WORD;
                            dm_address <= w_reqWord0;
                            dm_dmWr    <= 1'b1;
                            dm_dataWr  <= req_wdata;
                        end else begin
                            r_state    <= RD0;
                            dm_dmCtrl  <= c_DM_WORD;
                            dm_address <= w_reqWord0;
                        end
                    end
                end
                RD0: begin
                    r_w0 <= dm_dataRd;
                    if (r_span) begin
                        r_state    <= RD1;
                        dm_dmCtrl  <= c_DM_WORD;
                        dm_address <= w_word1;
                    end else if (r_wr) begin
                        r_state    <= WR0;
                        dm_dmCtrl  <= c_DM_WORD;
                        dm_address <= w_word0;
                        dm_dmWr    <= 1'b1;
                        dm_dataWr  <= w_mergeRd0;
                    end else begin
                        r_state   <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= w_loadRd0;
                    end
                end
                RD1: begin
                    r_w1 <= dm_dataRd;
                    if (r_wr) begin
                        r_state    <= WR0;
                        dm_dmCtrl  <= c_DM_WORD;
                        dm_address <= w_word0;
                        dm_dmWr    <= 1'b1;
                        dm_dataWr  <= w_mergeW0;
                    end else begin
                        r_state   <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= w_loadRd1;
                    end
                end
                WR0: begin
                    if (r_span) begin
                        r_state    <= WR1;
                        dm_dmCtrl  <= c_DM_WORD;
                        dm_address <= w_word1;
                        dm_dmWr    <= 1'b1;
                        dm_dataWr  <= w_mergeW1;
                    end else begin
                        r_state   <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end
                end
                WR1: begin
                    r_state   <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                DONE: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
